// File: rtl/cpu_out_uart.sv
// cpu_out_uart: memory-mapped UART transmitter for a soft core.
// Words written at the I/O address are queued in a small FIFO and shifted out
// as four 8N1 frames each, byte 0 first, LSB first. CPUIn reports the status.
module cpu_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] CPUOut,
    input  logic        IOWrite,
    output logic [31:0] CPUIn,
    output logic        TxD,
    output logic        Busy
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH     = 5'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [4:0]       count;
    logic             overflow;
    logic             full, push, pop, baud_done;

    state_t           state, state_nxt;
    logic [15:0]      baud_cnt, baud_nxt;
    logic [2:0]       bit_idx, bit_nxt, bit_inc;
    logic [1:0]       byte_idx, byte_nxt;
    logic             txd_nxt;
    logic [31:0]      head;
    logic [7:0]       cur_byte;

    // Occupancy drives full/empty; pointers alone cannot tell the two apart.
    assign full      = (count == DEPTH);
    assign baud_done = (baud_cnt == BAUD_LAST);
    // The head word leaves the FIFO only when byte 3's stop bit has finished.
    assign pop       = (state == STOP) && baud_done && (byte_idx == 2'd3);
    // A write into a full FIFO still fits when the head is popped on the same edge.
    assign push      = IOWrite && (!full || pop);
    assign bit_inc   = bit_idx + 3'd1;
    assign head      = mem[rd_ptr];

    assign Busy  = (count != 5'd0) || (state != IDLE);
    assign CPUIn = {24'd0, count, overflow, full, Busy};

    // Select the byte of the head word currently being framed.
    always_comb begin
        cur_byte = head[7:0];
        case (byte_idx)
            2'd0: cur_byte = head[7:0];
            2'd1: cur_byte = head[15:8];
            2'd2: cur_byte = head[23:16];
            2'd3: cur_byte = head[31:24];
            default: cur_byte = head[7:0];
        endcase
    end

    // FIFO storage; contents are data only and need no reset.
    always_ff @(posedge CLK) begin
        if (push && !Reset) begin
            mem[wr_ptr] <= CPUOut;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (IOWrite && full && !pop) overflow <= 1'b1;
        end
    end

    // Transmitter state register; TxD is registered so the line never glitches.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            TxD      <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            TxD      <= txd_nxt;
        end
    end

    // Next-state logic: the baud counter restarts at every bit boundary and
    // the line value for the coming bit is chosen at the same time.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 16'd1;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        txd_nxt   = TxD;
        case (state)
            IDLE: begin
                baud_nxt = 16'd0;
                txd_nxt  = 1'b1;
                if (count != 5'd0) begin
                    state_nxt = START;
                    bit_nxt   = 3'd0;
                    byte_nxt  = 2'd0;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_nxt = DATA;
                    baud_nxt  = 16'd0;
                    bit_nxt   = 3'd0;
                    txd_nxt   = cur_byte[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_nxt = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_nxt = bit_inc;
                        txd_nxt = cur_byte[bit_inc];
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_nxt = 16'd0;
                    if (byte_idx != 2'd3) begin
                        state_nxt = START;
                        byte_nxt  = byte_idx + 2'd1;
                        txd_nxt   = 1'b0;
                    end else begin
                        byte_nxt = 2'd0;
                        // Continue straight into the next word if one remains
                        // after this pop, including a word pushed on this edge.
                        if ((count > 5'd1) || push) begin
                            state_nxt = START;
                            txd_nxt   = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            txd_nxt   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_out_uart.sv
// tb_cpu_out_uart: checks cpu_out_uart (4 clocks/bit, 4-word FIFO) against a
// queue-based model of the serial line, plus hand-computed scenario values.
module tb_cpu_out_uart;

    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int WORD_CYC = 40 * CPB;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] CPUOut;
    logic        IOWrite;
    logic [31:0] CPUIn;
    logic        TxD;
    logic        Busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    cpu_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .CPUOut(CPUOut), .IOWrite(IOWrite),
        .CPUIn(CPUIn), .TxD(TxD), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The queue holds the accepted words; the head is the word on the line,
    // m_t is the cycle offset inside its 160-cycle, 40-bit transmission.
    logic [31:0] mq[$];
    bit          m_active = 1'b0;
    int          m_t      = 0;
    bit          m_ovf    = 1'b0;
    bit          m_valid  = 1'b0;
    int          m_sz;
    bit          m_pop, m_start;

    function automatic logic line_bit(input logic [31:0] w, input int t);
        int k, b, p;
        k = t / CPB;
        b = k / 10;
        p = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[8*b + p - 1];
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (Reset === 1'b1) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            m_sz    = mq.size();
            m_pop   = m_active && (m_t == WORD_CYC - 1);
            m_start = !m_active && (m_sz > 0);
            if (m_pop) void'(mq.pop_front());
            if (IOWrite) begin
                if (m_sz < DEPTH || m_pop) mq.push_back(CPUOut);
                else m_ovf = 1'b1;
            end
            if (m_pop) begin
                m_active = (mq.size() > 0);
                m_t      = 0;
            end else if (m_start) begin
                m_active = 1'b1;
                m_t      = 0;
            end else if (m_active) begin
                m_t++;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    logic        e_busy, e_tx;
    logic [31:0] e_in;
    always @(negedge CLK) begin
        if (m_valid) begin
            e_busy = (mq.size() != 0) || m_active;
            e_in   = {24'd0, 5'(mq.size()), m_ovf, (mq.size() == DEPTH), e_busy};
            e_tx   = m_active ? line_bit(mq[0], m_t) : 1'b1;
            chk("model_txd",   32'(TxD),  32'(e_tx));
            chk("model_busy",  32'(Busy), 32'(e_busy));
            chk("model_cpuin", CPUIn,     e_in);
        end
    end

    // ---------------- helpers (all called at a falling edge) ----------------
    task automatic do_reset();
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        IOWrite = 1'b1;
        CPUOut  = w;
        @(negedge CLK);
        IOWrite = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b);
        int n;
        n = 0;
        b = 8'h00;
        while (TxD !== 1'b0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 1000) begin
            chk("rx_timeout", 32'(n), 32'd0);
            return;
        end
        repeat (CPB / 2) @(negedge CLK);
        chk("rx_start_bit", 32'(TxD), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge CLK);
            b[i] = TxD;
        end
        repeat (CPB) @(negedge CLK);
        chk("rx_stop_bit", 32'(TxD), 32'd1);
    endtask

    task automatic wait_busy_low();
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) chk("busy_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0]  rb;
    logic [31:0] words [12];
    int          t0, wn;

    initial begin
        Reset   = 1'b1;
        IOWrite = 1'b0;
        CPUOut  = 32'd0;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        chk("reset_cpuin", CPUIn, 32'h0);
        chk("reset_txd", 32'(TxD), 32'd1);
        chk("reset_busy", 32'(Busy), 32'd0);

        // Reset wins over a simultaneous write.
        Reset   = 1'b1;
        IOWrite = 1'b1;
        CPUOut  = 32'h12345678;
        @(negedge CLK);
        Reset   = 1'b0;
        IOWrite = 1'b0;
        chk("reset_drops_write", CPUIn, 32'h0);

        // Single word.
        write_word(32'h44332211);
        t0 = cyc;
        chk("single_busy_after_write", 32'(Busy), 32'd1);
        rx_byte(rb); chk("single_b0", 32'(rb), 32'h11);
        rx_byte(rb); chk("single_b1", 32'(rb), 32'h22);
        rx_byte(rb); chk("single_b2", 32'(rb), 32'h33);
        rx_byte(rb); chk("single_b3", 32'(rb), 32'h44);
        wait_busy_low();
        chk("single_busy_fall_cycle", 32'(cyc - t0), 32'd161);
        chk("single_cpuin_end", CPUIn, 32'h0);

        // Fill to full plus one.
        do_reset();
        IOWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            CPUOut = 32'hA0 + 32'(i);
            @(negedge CLK);
        end
        IOWrite = 1'b0;
        chk("fill_cpuin", CPUIn, 32'h27);
        wait_busy_low();
        chk("fill_ovf_sticky", CPUIn, 32'h4);

        // Push on the exact pop edge with the FIFO full.
        do_reset();
        IOWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CPUOut = 32'h01020304 * (32'(i) + 1);
            @(negedge CLK);
        end
        IOWrite = 1'b0;
        repeat (157) @(negedge CLK);
        chk("pop_edge_before", CPUIn, 32'h23);
        write_word(32'hDEADBEEF);
        chk("pop_edge_after", CPUIn, 32'h23);
        for (int i = 0; i < 12; i++) rx_byte(rb);
        rx_byte(rb); chk("pop_last_b0", 32'(rb), 32'hEF);
        rx_byte(rb); chk("pop_last_b1", 32'(rb), 32'hBE);
        rx_byte(rb); chk("pop_last_b2", 32'(rb), 32'hAD);
        rx_byte(rb); chk("pop_last_b3", 32'(rb), 32'hDE);
        wait_busy_low();
        chk("pop_no_ovf", CPUIn, 32'h0);

        // Back-to-back words.
        do_reset();
        IOWrite = 1'b1;
        CPUOut  = 32'h000000AA;
        @(negedge CLK);
        CPUOut  = 32'h00000055;
        @(negedge CLK);
        IOWrite = 1'b0;
        wn = 0;
        while (TxD !== 1'b0 && wn < 100) begin @(negedge CLK); wn++; end
        t0 = cyc;
        wait_busy_low();
        chk("b2b_total_cycles", 32'(cyc - t0), 32'd320);

        // Mid-frame reset during data bit 3 of byte 1.
        do_reset();
        write_word(32'h0000A53C);
        repeat (57) @(negedge CLK);
        chk("mid_byte1_d3", 32'(TxD), 32'd0);
        do_reset();
        chk("mid_reset_cpuin", CPUIn, 32'h0);
        chk("mid_reset_txd", 32'(TxD), 32'd1);
        chk("mid_reset_busy", 32'(Busy), 32'd0);
        write_word(32'h000000FF);
        rx_byte(rb); chk("mid_after_b0", 32'(rb), 32'hFF);
        rx_byte(rb); chk("mid_after_b1", 32'(rb), 32'h00);
        rx_byte(rb); chk("mid_after_b2", 32'(rb), 32'h00);
        rx_byte(rb); chk("mid_after_b3", 32'(rb), 32'h00);
        wait_busy_low();

        // Pointer wrap: 12 distinct words, writes paced on occupancy.
        do_reset();
        for (int i = 0; i < 12; i++) words[i] = {8'(i + 1), 24'($urandom)};
        fork
            begin
                for (int wi = 0; wi < 12; wi++) begin
                    wn = 0;
                    while (CPUIn[7:3] >= 5'(DEPTH) && wn < 2000) begin
                        @(negedge CLK);
                        wn++;
                    end
                    write_word(words[wi]);
                end
            end
            begin
                logic [7:0] wb;
                for (int rj = 0; rj < 48; rj++) begin
                    rx_byte(wb);
                    chk("wrap_byte", 32'(wb), 32'(words[rj / 4][8 * (rj % 4) +: 8]));
                end
            end
        join
        wait_busy_low();
        chk("wrap_no_ovf", 32'(CPUIn[2]), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            Reset   = ($urandom_range(0, 1499) == 0);
            IOWrite = ($urandom_range(0, 49) == 0);
            CPUOut  = $urandom;
            @(negedge CLK);
        end
        Reset   = 1'b0;
        IOWrite = 1'b0;
        wait_busy_low();
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_out_uart.md
CPU_OUT_UART -- requirements
Module: cpu_out_uart

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per UART bit; legal range is 2 to 65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of 32-bit words buffered; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase names them (CLK, Reset).
REQ-004 The block SHALL have these ports, clock and reset first:
- CLK  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- CPUOut  input  32  word written by the core to the I/O address.
- IOWrite  input  1  one-cycle strobe meaning CPUOut is valid this cycle.
- CPUIn  output  32  status word read back by the core at the I/O address.
- TxD  output  1  UART serial output, idle high.
- Busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Function
REQ-005 On a rising edge with IOWrite=1 and the FIFO not full, the block SHALL push CPUOut into the FIFO tail.
REQ-006 On a rising edge with IOWrite=1 and the FIFO full, the block SHALL discard the write, leave the FIFO unchanged, and set the sticky Overflow flag.
REQ-007 Overflow SHALL clear only on Reset.
REQ-008 The exception to REQ-006 is when a pop occurs on the same edge: the push SHALL be accepted, Overflow SHALL not be set, and the count SHALL stay unchanged.
REQ-009 CPUIn SHALL be combinational from registered state, with these fields:
- [0] Busy
- [1] Full
- [2] Overflow
- [7:3] occupancy count, 0 to FIFO_DEPTH
- [31:8] zero
REQ-010 The transmitter FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-011 Each word SHALL be sent as four 8N1 frames, byte 0 (CPUOut[7:0]) first and byte 3 last, with data bits LSB first.
REQ-012 TxD SHALL be a registered output driven high in IDLE and STOP, low in START, and equal to the current data bit in DATA.
REQ-013 Each bit period SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-014 The FSM transitions SHALL be:
- IDLE to START on the edge after the FIFO becomes non-empty.
- START to DATA after one bit period.
- DATA to STOP after eight bit periods.
- STOP to START (next byte) after one bit period, when the byte index is below 3.
- After byte 3's stop bit: pop the FIFO head, then go to START if a further word remains, else to IDLE.
REQ-015 Frames SHALL be back-to-back with no idle gap between bytes or between words.
REQ-016 The FIFO head SHALL remain unpopped until its final stop bit completes, so occupancy includes the word being sent.
REQ-017 With the FSM in IDLE and the FIFO empty, a write sampled at edge E SHALL make TxD low after edge E+1, and Busy high after edge E.
REQ-018 Busy SHALL fall on the same edge as the final pop that leaves the FIFO empty.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 Full and empty SHALL be derived from the occupancy count, never from pointer equality alone.

Reset
REQ-021 On a rising edge with Reset=1, the block SHALL:
- put the FSM in IDLE
- drive TxD=1
- set Busy=0, the count to 0, Overflow to 0 and both pointers to 0
- clear the baud counter and byte/bit indices
REQ-022 Reset SHALL take priority over IOWrite on the same edge; that write is dropped.
REQ-023 Reset mid-frame SHALL abort the frame immediately, with no partial stop bit emitted; FIFO contents are discarded.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-024 Single word: write 0x44332211 with the block idle -> TxD emits bytes 0x11, 0x22, 0x33, 0x44 as 8N1 at 4 cycles/bit over 160 cycles; Busy then falls and CPUIn reads 0x00000000.
REQ-025 Fill to full: five writes on consecutive cycles while idle -> the first four are accepted and the fifth sets Overflow; CPUIn reads 0x00000027 after the fifth edge (count 4, Overflow, Full, Busy).
REQ-026 Push on pop: keep the FIFO full and write 0xDEADBEEF on the exact edge the head's final stop bit ends -> the word is accepted, Overflow stays 0, the count stays 4, and 0xDEADBEEF is the last word transmitted.
REQ-027 Back-to-back words: queue 0x000000AA and 0x00000055 -> eight contiguous frames with no high gap beyond the stop bits; total 320 cycles from the first start bit to the end of the last stop bit.
REQ-028 Mid-frame reset: assert Reset during DATA bit 3 of byte 1 -> TxD=1, CPUIn=0 and Busy=0 on the next edge; a subsequent write of 0x000000FF transmits correctly from byte 0.
REQ-029 Pointer wrap: stream 12 distinct words with writes paced to avoid overflow -> all 48 bytes are received in order and Overflow stays 0.
